// File: rtl/corr_pkg.sv
// Shared types and constants for the correlator load scheduler.
package corr_pkg;

    localparam int DATA_LEN    = 32;
    localparam int CLK_DIV_DEF = 166667;
    localparam int FRAME_CNT_W = 12;

    typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_SHIFT,
        ST_WAIT_ACK,
        ST_DONE
    } corr_ld_state_t;

    function automatic frame_cnt_t frame_cnt_inc(input frame_cnt_t c);
        return (&c) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/corr_sck_gen.sv
// Serial clock divider: toggles sck every CLK_DIV/2 cycles while enabled,
// flags the cycle of each falling and rising transition.
module corr_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clki,
    input  logic rst_n,
    input  logic en,
    output logic sck,
    output logic fall_tick,
    output logic rise_tick
);

    localparam int HALF = CLK_DIV / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] cnt_q;
    logic          sck_q;
    logic          terminal;

    assign terminal  = en && (cnt_q == CW'(HALF - 1));
    assign fall_tick = terminal && sck_q;
    assign rise_tick = terminal && !sck_q;
    assign sck       = sck_q;

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else if (!en) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else if (terminal) begin
            cnt_q <= '0;
            sck_q <= ~sck_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/corr_load_sched.sv
// Round-robin scheduler and bit-serial shifter for the correlator load port.
// Define CORR_MSB_FIRST_EN to shift frames MSB first (default LSB first).
module corr_load_sched #(
    parameter int CLK_DIV     = corr_pkg::CLK_DIV_DEF,
    parameter int DATA_LEN    = corr_pkg::DATA_LEN,
    parameter int REP_W       = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                clki,
    input  logic                rst_n,
    input  logic                req0,
    input  logic [DATA_LEN-1:0] word0,
    input  logic [REP_W-1:0]    rep0,
    output logic                gnt0,
    output logic                done0,
    input  logic                req1,
    input  logic [DATA_LEN-1:0] word1,
    input  logic [REP_W-1:0]    rep1,
    output logic                gnt1,
    output logic                done1,
    output logic                corr_sck,
    output logic                corr_sdi,
    input  logic                corr_ack,
    output logic                busy,
    output logic                err_timeout,
    input  logic                err_clr,
    output logic [11:0]         frames_sent
);
    import corr_pkg::*;

    localparam int BW = $clog2(DATA_LEN + 1);
    localparam int IW = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    corr_ld_state_t      state_q;
    logic                ack_s1_q, ack_s2_q;
    logic                owner_q, last_q;
    logic [DATA_LEN-1:0] word_q;
    logic [REP_W-1:0]    rep_q, rep_cnt_q;
    logic [BW-1:0]       bit_cnt_q;
    logic [TW-1:0]       tmo_q;
    logic                gnt0_q, gnt1_q, done0_q, done1_q;
    logic                sdi_q, err_q;
    frame_cnt_t          frames_q;

    logic                sck_en, fall_tick, sck_rise_unused;
    logic                pick;
    logic [IW-1:0]       bit_sel;
    logic                rep_last, tmo_hit;

    corr_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clki      (clki),
        .rst_n     (rst_n),
        .en        (sck_en),
        .sck       (corr_sck),
        .fall_tick (fall_tick),
        .rise_tick (sck_rise_unused)
    );

    assign sck_en = (state_q == ST_SHIFT) || (state_q == ST_WAIT_ACK);

    // On a tie the requester not served last wins; otherwise whoever asks.
    assign pick = (req0 && req1) ? ~last_q : req1;

`ifdef CORR_MSB_FIRST_EN
    assign bit_sel = IW'(DATA_LEN - 1) - IW'(bit_cnt_q);
`else
    assign bit_sel = IW'(bit_cnt_q);
`endif

    assign rep_last = ((REP_W+1)'(rep_cnt_q) + 1'b1) == (REP_W+1)'(rep_q);
    assign tmo_hit  = fall_tick && (tmo_q == TW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ack_s1_q  <= 1'b0;
            ack_s2_q  <= 1'b0;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            word_q    <= '0;
            rep_q     <= '0;
            rep_cnt_q <= '0;
            bit_cnt_q <= '0;
            tmo_q     <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            sdi_q     <= 1'b0;
            err_q     <= 1'b0;
            frames_q  <= '0;
        end else begin
            ack_s1_q <= corr_ack;
            ack_s2_q <= ack_s1_q;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            if (err_clr) err_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        owner_q   <= pick;
                        word_q    <= pick ? word1 : word0;
                        rep_q     <= pick ? ((rep1 == '0) ? REP_W'(1) : rep1)
                                          : ((rep0 == '0) ? REP_W'(1) : rep0);
                        rep_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        gnt0_q    <= ~pick;
                        gnt1_q    <= pick;
                        state_q   <= ST_GRANT;
                    end
                end
                ST_GRANT: state_q <= ST_SHIFT;
                ST_SHIFT: begin
                    if (fall_tick) begin
                        if (bit_cnt_q == BW'(DATA_LEN)) begin
                            sdi_q   <= 1'b0;
                            tmo_q   <= '0;
                            state_q <= ST_WAIT_ACK;
                        end else begin
                            sdi_q     <= word_q[bit_sel];
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    // Ack is checked before timeout so it wins a same-cycle tie.
                    if (ack_s2_q) begin
                        frames_q  <= frame_cnt_inc(frames_q);
                        rep_cnt_q <= rep_cnt_q + 1'b1;
                        if (rep_last) begin
                            done0_q <= ~owner_q;
                            done1_q <= owner_q;
                            state_q <= ST_DONE;
                        end else begin
                            bit_cnt_q <= '0;
                            state_q   <= ST_SHIFT;
                        end
                    end else if (tmo_hit) begin
                        err_q   <= 1'b1;
                        done0_q <= ~owner_q;
                        done1_q <= owner_q;
                        state_q <= ST_DONE;
                    end else if (fall_tick) begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    last_q  <= owner_q;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign corr_sdi    = sdi_q;
    assign busy        = (state_q != ST_IDLE);
    assign err_timeout = err_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_corr_load_sched.sv
// Self-checking bench for corr_load_sched: directed jobs plus randomized jobs
// checked against a frame-level reference model.
module tb_corr_load_sched;

    localparam int DL = 32;
    localparam int RW = 4;

    logic          clki = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [DL-1:0] word0 = '0, word1 = '0;
    logic [RW-1:0] rep0 = '0, rep1 = '0;
    logic          gnt0, gnt1, done0, done1;
    logic          corr_sck, corr_sdi, busy, err_timeout;
    logic          corr_ack = 1'b0, err_clr = 1'b0;
    logic [11:0]   frames_sent;

    corr_load_sched #(.CLK_DIV(4), .DATA_LEN(DL), .REP_W(RW), .ACK_TIMEOUT(8)) dut (
        .clki(clki), .rst_n(rst_n),
        .req0(req0), .word0(word0), .rep0(rep0), .gnt0(gnt0), .done0(done0),
        .req1(req1), .word1(word1), .rep1(rep1), .gnt1(gnt1), .done1(done1),
        .corr_sck(corr_sck), .corr_sdi(corr_sdi), .corr_ack(corr_ack),
        .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr),
        .frames_sent(frames_sent)
    );

    always #5 clki = ~clki;

    int   n_chk = 0, n_pass = 0;
    int   g0, g1, d0, d1;
    logic sck_prev = 1'b0;
    bit   bits[$];
    int   exp_frames = 0;
    logic exp_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clki cycle; observe at the falling edge, record data seen at each sck fall.
    task automatic step();
        @(negedge clki);
        if (gnt0)  g0++;
        if (gnt1)  g1++;
        if (done0) d0++;
        if (done1) d1++;
        if (sck_prev && !corr_sck) bits.push_back(corr_sdi);
        sck_prev = corr_sck;
    endtask

    function automatic logic [31:0] frame_order(input logic [31:0] w);
        logic [31:0] r;
`ifdef CORR_MSB_FIRST_EN
        for (int i = 0; i < 32; i++) r[i] = w[31-i];
`else
        r = w;
`endif
        return r;
    endfunction

    task automatic serve_job(input string tag, input int owner, input logic [31:0] w,
                             input int rep, input logic [7:0] ack_mask, input bit drop_req);
        int          n;
        int          nfr;
        logic [31:0] got;
        bit          timed_out;
        timed_out = 0;
        g0 = 0; g1 = 0; d0 = 0; d1 = 0;
        n = 0;
        while (g0 + g1 == 0 && n < 60) begin step(); n++; end
        chk({tag, "/gnt_owner"}, owner ? g1 : g0, 1);
        chk({tag, "/gnt_other"}, owner ? g0 : g1, 0);
        bits.delete();
        if (drop_req) begin
            req0 = 0; req1 = 0;
            word0 = $urandom; word1 = $urandom;
            rep0 = RW'($urandom); rep1 = RW'($urandom);
        end
        nfr = (rep == 0) ? 1 : rep;
        for (int f = 0; f < nfr && !timed_out; f++) begin
            n = 0;
            while (bits.size() < 32 && n < 400) begin step(); n++; end
            got = '0;
            for (int i = 0; i < 32 && i < bits.size(); i++) got[i] = bits[i];
            chk({tag, "/frame"}, got, frame_order(w));
            if (ack_mask[f]) begin
                repeat (10) step();
                corr_ack = 1; step(); step();
                corr_ack = 0; step();
                bits.delete();
                if (exp_frames < 4095) exp_frames++;
            end else begin
                timed_out = 1;
                exp_err = 1;
            end
        end
        n = 0;
        while ((owner ? d1 : d0) == 0 && n < 200) begin step(); n++; end
        chk({tag, "/done_owner"}, owner ? d1 : d0, 1);
        chk({tag, "/done_other"}, owner ? d0 : d1, 0);
        chk({tag, "/frames_sent"}, 32'(frames_sent), 32'(exp_frames));
        chk({tag, "/err_timeout"}, 32'(err_timeout), 32'(exp_err));
        step();
        chk({tag, "/busy_after"}, 32'(busy), 0);
        chk({tag, "/gnt_once"}, owner ? g1 : g0, 1);
    endtask

    initial begin
        int          own;
        int          rp;
        logic [31:0] w;
        logic [7:0]  mask;

        // Both requesters pending from reset: round robin must start with 0.
        req0 = 1; req1 = 1;
        word0 = 32'h1357_9BDF; word1 = 32'hF0E1_D2C3;
        rep0 = 1; rep1 = 1;
        repeat (3) @(negedge clki);
        chk("reset/busy", 32'(busy), 0);
        chk("reset/sck", 32'(corr_sck), 0);
        chk("reset/sdi", 32'(corr_sdi), 0);
        chk("reset/gnt", {30'd0, gnt1, gnt0}, 0);
        chk("reset/done", {30'd0, done1, done0}, 0);
        chk("reset/err", 32'(err_timeout), 0);
        chk("reset/frames", 32'(frames_sent), 0);
        rst_n = 1;
        serve_job("cont0", 0, 32'h1357_9BDF, 1, 8'hFF, 0);
        serve_job("cont1", 1, 32'hF0E1_D2C3, 1, 8'hFF, 0);
        serve_job("cont2", 0, 32'h1357_9BDF, 1, 8'hFF, 0);
        serve_job("cont3", 1, 32'hF0E1_D2C3, 1, 8'hFF, 1);
        repeat (3) step();

        req0 = 1; word0 = 32'hA5A5_0001; rep0 = 1;
        serve_job("single", 0, 32'hA5A5_0001, 1, 8'hFF, 1);
        repeat (3) step();

        req1 = 1; word1 = 32'h0F0F_8421; rep1 = 3;
        serve_job("rep3", 1, 32'h0F0F_8421, 3, 8'hFF, 1);
        repeat (3) step();

        req0 = 1; word0 = 32'hDEAD_BEEF; rep0 = 0;
        serve_job("rep0", 0, 32'hDEAD_BEEF, 0, 8'hFF, 1);
        repeat (3) step();

        req1 = 1; word1 = 32'h8000_0003; rep1 = 2;
        serve_job("timeout", 1, 32'h8000_0003, 2, 8'h00, 1);
        err_clr = 1; step(); err_clr = 0;
        exp_err = 0;
        chk("err_clr", 32'(err_timeout), 0);
        repeat (3) step();

        for (int j = 0; j < 8; j++) begin
            own  = $urandom_range(0, 1);
            w    = $urandom;
            rp   = $urandom_range(0, 3);
            mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            if (own == 1) begin req1 = 1; word1 = w; rep1 = RW'(rp); end
            else          begin req0 = 1; word0 = w; rep0 = RW'(rp); end
            serve_job("rand", own, w, rp, mask, 1);
            repeat ($urandom_range(1, 4)) step();
        end

        // Reset in the middle of a frame, then restart the same word.
        req0 = 1; word0 = 32'h5A5A_C3C3; rep0 = 1;
        g0 = 0; g1 = 0;
        begin
            int n;
            n = 0;
            while (g0 == 0 && n < 60) begin step(); n++; end
            bits.delete();
            n = 0;
            while (bits.size() < 11 && n < 200) begin step(); n++; end
            chk("midreset/reached_bit10", 32'(bits.size()), 11);
        end
        rst_n = 0;
        #1;
        exp_frames = 0; exp_err = 0;
        chk("midreset/busy", 32'(busy), 0);
        chk("midreset/sck", 32'(corr_sck), 0);
        chk("midreset/sdi", 32'(corr_sdi), 0);
        chk("midreset/frames", 32'(frames_sent), 0);
        req0 = 0;
        repeat (2) @(negedge clki);
        rst_n = 1;
        sck_prev = 0;
        step();
        chk("midreset/idle", 32'(busy), 0);
        req0 = 1;
        serve_job("restart", 0, 32'h5A5A_C3C3, 1, 8'hFF, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
